// File: rtl/vec_pkg.sv
// Shared constants, state type and element packing helper for the vector-set
// loader and the cross-product stage that consumes its flat bus.
package vec_pkg;

  localparam int DATA_W    = 8;
  localparam int ELEMS     = 4;
  localparam int VECS      = 6;
  localparam int SET_BYTES = VECS * ELEMS;
  localparam int FLAT_W    = SET_BYTES * DATA_W;
  localparam int CNT_W     = $clog2(SET_BYTES);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SET_BYTES - 1);

  typedef enum logic {
    FILL,
    FULL
  } state_e;

  // Flat element index of element e (0..3) of vector v (0..5 for a..f).
  function automatic int elem_idx(input int v, input int e);
    return v * ELEMS + e;
  endfunction

endpackage

// File: rtl/vec_fill_buffer.sv
// Fill-side storage for one vector set: one indexed byte write port and a
// flat parallel read of all SET_BYTES entries in vec_pkg packing order.
module vec_fill_buffer
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [FLAT_W-1:0] rd_flat
);

  logic [DATA_W-1:0] mem_q [SET_BYTES];
  logic [DATA_W-1:0] mem_d [SET_BYTES];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // NOTE: this array is small and its contents are visible on vec_out after a
  // transfer, so it is reset like any other flop rather than left as RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SET_BYTES; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int v = 0; v < VECS; v++) begin
      for (int e = 0; e < ELEMS; e++) begin
        rd_flat[elem_idx(v, e)*DATA_W +: DATA_W] = mem_q[elem_idx(v, e)];
      end
    end
  end

endmodule

// File: rtl/vec_set_loader.sv
// Byte-stream to vector-set loader with a double-buffered registered output.
// Optional framing check on s_last enabled by VEC_SET_LOADER_FRAME_CHECK_EN.
module vec_set_loader
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [FLAT_W-1:0] vec_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLAT_W-1:0] vec_out_q, vec_out_d;
  logic              out_valid_q, out_valid_d;
  logic              wr_en;
  logic [FLAT_W-1:0] fill_flat;

`ifdef VEC_SET_LOADER_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  vec_fill_buffer u_fill_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_data (s_data),
    .rd_flat (fill_flat)
  );

  assign s_ready = (state_q == FILL);

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_out_d   = vec_out_q;
    out_valid_d = out_valid_q;
    wr_en       = 1'b0;
`ifdef VEC_SET_LOADER_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif
    unique case (state_q)
      FILL: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (s_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = FULL;
`ifdef VEC_SET_LOADER_FRAME_CHECK_EN
            if (!s_last) begin
              state_d     = FILL;
              frame_err_d = 1'b1;
            end
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef VEC_SET_LOADER_FRAME_CHECK_EN
            if (s_last) begin
              cnt_d       = '0;
              frame_err_d = 1'b1;
            end
`endif
          end
        end
      end
      FULL: begin
        // Output slot is free or being emptied this edge: hand over, no bubble.
        if (!out_valid_q || out_ready) begin
          vec_out_d   = fill_flat;
          out_valid_d = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      vec_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_out_q   <= vec_out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef VEC_SET_LOADER_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign vec_out   = vec_out_q;
  assign out_valid = out_valid_q;

endmodule
